pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register for the instruction path (IF/ID and later stages).
- Carries an instruction word and its address with a valid/ready handshake.
- Provides a 2-entry skid buffer, so the stage sustains one transfer per cycle while its ready output is driven from a register.
- Supports flush (jump/branch kill), substitutes a NOP instruction on bubbles, and keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_stage_skid.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Instruction-path pipeline stage with a 2-entry skid buffer, flush,
// NOP substitution on bubbles and saturating stall/flush counters.
module pipe_stage_skid #(
    parameter int unsigned      DW         = 32,
    parameter int unsigned      AW         = 32,
    parameter logic [DW-1:0]    NOP_INST   = 32'h00000013,
    parameter logic [AW-1:0]    RESET_ADDR = '0,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_inst,
    input  logic [AW-1:0]    in_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_inst,
    output logic [AW-1:0]    out_addr,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            in_ready_q;
    logic            in_fire;
    logic            out_fire;
    logic            load_main;
    logic            main_from_skid;
    logic            load_skid;
    logic [DW-1:0]   main_inst;
    logic [AW-1:0]   main_addr;
    logic [DW-1:0]   skid_inst;
    logic [AW-1:0]   skid_addr;

    assign in_ready = in_ready_q;
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    // in_ready is a flop so it never sees out_ready combinationally
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != S_SKID);
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = S_FULL;
                        load_main = 1'b1;
                    end
                end
                S_FULL: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = S_SKID;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (out_fire) begin
                        state_nxt      = S_FULL;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        occupancy = 2'd0;
        unique case (state)
            S_EMPTY: begin
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
            S_FULL: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            S_SKID: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    assign out_inst = out_valid ? main_inst : NOP_INST;
    assign out_addr = main_addr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_inst <= NOP_INST;
            main_addr <= RESET_ADDR;
        end else if (load_main) begin
            main_inst <= main_from_skid ? skid_inst : in_inst;
            main_addr <= main_from_skid ? skid_addr : in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_inst <= in_inst;
            skid_addr <= in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure,
// flush cases and counter saturation on a narrow-counter instance.
module tb_pipe_stage_skid;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_addr;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_inst;
    logic [31:0] s_out_addr;
    logic [1:0]  s_occupancy;
    logic [2:0]  s_stall_cnt;
    logic [2:0]  s_flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    pipe_stage_skid #(.CNT_W(3)) u_sat (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_inst   (in_inst),
        .in_addr   (in_addr),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_inst  (s_out_inst),
        .out_addr  (s_out_addr),
        .occupancy (s_occupancy),
        .stall_cnt (s_stall_cnt),
        .flush_cnt (s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        in_valid = 1'b1;
        in_addr  = a;
        in_inst  = a ^ KEY;
    endtask

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        push(32'h999);
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, NOP);
        check("rst_out_addr", out_addr, 0);
        check("rst_occ", occupancy, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_flush", flush_cnt, 0);
        rstn = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
        in_valid = 1'b0;

        // streaming: one transfer per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(32'(i * 4));
            tick();
            check("str_in_ready", in_ready, 1);
            check("str_valid", out_valid, 1);
            check("str_addr", out_addr, 64'(i * 4));
            check("str_inst", out_inst, 64'(32'(i * 4) ^ KEY));
        end
        in_valid = 1'b0;
        tick();
        check("str_end_valid", out_valid, 0);
        check("str_end_inst", out_inst, NOP);
        check("str_end_addr", out_addr, 32'h3C);
        check("str_stall", stall_cnt, 0);

        // backpressure fills the skid entry
        out_ready = 1'b0;
        push(32'h100);
        tick();
        check("bp_occ1", occupancy, 1);
        push(32'h104);
        tick();
        check("bp_occ2", occupancy, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_addr0", out_addr, 32'h100);
        check("bp_stall1", stall_cnt, 1);
        in_valid = 1'b0;
        tick();
        tick();
        check("bp_stall3", stall_cnt, 3);
        check("bp_hold_addr", out_addr, 32'h100);
        check("bp_hold_inst", out_inst, 32'h100 ^ KEY);
        out_ready = 1'b1;
        tick();
        check("bp_addr1", out_addr, 32'h104);
        check("bp_inst1", out_inst, 32'h104 ^ KEY);
        check("bp_occ_after", occupancy, 1);
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_drained", out_valid, 0);
        check("bp_stall_end", stall_cnt, 3);

        // flush while in SKID, upstream offering 0x200
        out_ready = 1'b0;
        push(32'h180);
        tick();
        push(32'h184);
        tick();
        check("fs_occ2", occupancy, 2);
        push(32'h200);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fs_valid", out_valid, 0);
        check("fs_inst", out_inst, NOP);
        check("fs_occ", occupancy, 0);
        check("fs_addr", out_addr, 32'h180);
        check("fs_flush_cnt", flush_cnt, 1);
        check("fs_stall", stall_cnt, 4);
        tick();
        check("fs_no_200", out_valid, 0);
        check("fs_addr_hold", out_addr, 32'h180);

        // flush with concurrent out_fire and a discarded in_fire
        out_ready = 1'b1;
        push(32'h300);
        tick();
        check("fo_addr", out_addr, 32'h300);
        push(32'h250);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fo_valid", out_valid, 0);
        check("fo_occ", occupancy, 0);
        check("fo_addr_hold", out_addr, 32'h300);
        check("fo_flush_cnt", flush_cnt, 2);
        push(32'h304);
        tick();
        in_valid = 1'b0;
        check("fo_next_valid", out_valid, 1);
        check("fo_next_addr", out_addr, 32'h304);
        check("fo_next_inst", out_inst, 32'h304 ^ KEY);
        tick();
        check("fo_empty", out_valid, 0);

        // saturation on the CNT_W=3 instance
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("sat_rst_stall", s_stall_cnt, 0);
        check("sat_rst_flush", s_flush_cnt, 0);
        out_ready = 1'b0;
        push(32'h400);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("sat_stall", s_stall_cnt, 7);
        check("wide_stall", stall_cnt, 20);
        for (int i = 0; i < 10; i++) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            tick();
        end
        check("sat_flush", s_flush_cnt, 7);
        check("wide_flush", flush_cnt, 10);
        check("sat_stall_hold", s_stall_cnt, 7);
        check("wide_stall_hold", stall_cnt, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
